// File: rtl/step_controller.sv
`default_nettype none
// step_controller: CPU clock-step generator (MANUAL / AUTO / BURST) with
// debounced buttons and an address breakpoint that halts free runs. Rev 1.0
module step_controller #(
   parameter int DIV_WIDTH       = 18,
   parameter int BURST_WIDTH     = 8,
   parameter int ADDR_WIDTH      = 16,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   step_btn,
   input  logic                   mode_btn,
   input  logic [DIV_WIDTH-1:0]   div_limit,
   input  logic [BURST_WIDTH-1:0] run_count,
   input  logic                   bp_enable,
   input  logic [ADDR_WIDTH-1:0]  bp_addr,
   input  logic [ADDR_WIDTH-1:0]  addr,
   output logic                   step_pulse,
   output logic [1:0]             mode,
   output logic                   busy,
   output logic                   halted_bp,
   output logic [BURST_WIDTH-1:0] steps_remaining
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0] raw_btn;
   logic [1:0] press;
   logic       step_press;
   logic       mode_press;

   assign raw_btn = {mode_btn, step_btn};

   // Index 0 is the step button, index 1 the mode button.
   for (genvar g = 0; g < 2; g++) begin : g_btn
      logic             sync_a;
      logic             sync_b;
      logic             level;
      logic             level_d;
      logic [CNT_W-1:0] stable_cnt;

      always_ff @(posedge clk) begin
         if (reset) begin
            sync_a     <= 1'b0;
            sync_b     <= 1'b0;
            level      <= 1'b0;
            level_d    <= 1'b0;
            stable_cnt <= '0;
         end else begin
            sync_a  <= raw_btn[g];
            sync_b  <= sync_a;
            level_d <= level;
            if (sync_b != level) begin
               if (stable_cnt == CNT_LAST) begin
                  level      <= sync_b;
                  stable_cnt <= '0;
               end else begin
                  stable_cnt <= stable_cnt + 1'b1;
               end
            end else begin
               stable_cnt <= '0;
            end
         end
      end

      assign press[g] = level & ~level_d;
   end

   // A simultaneous mode press swallows the step press.
   assign mode_press = press[1];
   assign step_press = press[0] & ~press[1];

   typedef enum logic [1:0] {
      S_MANUAL     = 2'd0,
      S_AUTO       = 2'd1,
      S_BURST_IDLE = 2'd2,
      S_BURST_RUN  = 2'd3
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [DIV_WIDTH-1:0]   div_cnt;
   logic [DIV_WIDTH-1:0]   div_next;
   logic [BURST_WIDTH-1:0] steps_next;
   logic                   pulse_q;
   logic                   pulse_next;
   logic                   halted_next;
   logic                   busy_next;
   logic [1:0]             mode_next;
   logic                   slot;
   logic                   bp_hit;

   // >= rather than == so a live drop of div_limit below the count cannot
   // send the divider round the full counter range.
   assign slot   = (div_cnt >= div_limit);
   assign bp_hit = bp_enable && (addr == bp_addr);

   always_comb begin
      state_next  = state;
      div_next    = '0;
      steps_next  = steps_remaining;
      pulse_next  = 1'b0;
      halted_next = halted_bp;
      case (state)
         S_MANUAL: begin
            if (mode_press) begin
               state_next = S_AUTO;
            end else if (step_press) begin
               pulse_next  = 1'b1;
               halted_next = 1'b0;
            end
         end
         S_AUTO: begin
            if (mode_press) begin
               state_next = S_BURST_IDLE;
            end else begin
               div_next = slot ? '0 : div_cnt + 1'b1;
               if (slot) begin
                  if (bp_hit) begin
                     halted_next = 1'b1;
                     state_next  = S_MANUAL;
                  end else begin
                     pulse_next = 1'b1;
                  end
               end
            end
         end
         S_BURST_IDLE: begin
            if (mode_press) begin
               state_next = S_MANUAL;
            end else if (step_press && (run_count != '0)) begin
               steps_next  = run_count;
               halted_next = 1'b0;
               state_next  = S_BURST_RUN;
            end
         end
         S_BURST_RUN: begin
            if (mode_press) begin
               state_next = S_MANUAL;
               steps_next = '0;
            end else if (steps_remaining == '0) begin
               // busy stays up through the final pulse and drops here.
               state_next = S_BURST_IDLE;
            end else begin
               div_next = slot ? '0 : div_cnt + 1'b1;
               if (slot) begin
                  if (bp_hit) begin
                     halted_next = 1'b1;
                     state_next  = S_MANUAL;
                  end else begin
                     pulse_next = 1'b1;
                     steps_next = steps_remaining - 1'b1;
                  end
               end
            end
         end
         default: state_next = S_MANUAL;
      endcase

      case (state_next)
         S_AUTO:       mode_next = 2'd1;
         S_BURST_IDLE: mode_next = 2'd2;
         S_BURST_RUN:  mode_next = 2'd2;
         default:      mode_next = 2'd0;
      endcase
      busy_next = (state_next == S_BURST_RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= S_MANUAL;
         div_cnt         <= '0;
         steps_remaining <= '0;
         pulse_q         <= 1'b0;
         halted_bp       <= 1'b0;
         mode            <= 2'd0;
         busy            <= 1'b0;
      end else begin
         state           <= state_next;
         div_cnt         <= div_next;
         steps_remaining <= steps_next;
         pulse_q         <= pulse_next;
         halted_bp       <= halted_next;
         mode            <= mode_next;
         busy            <= busy_next;
      end
   end

   // Gate with reset so no enable escapes in the cycle reset is raised.
   assign step_pulse = pulse_q & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_step_controller.sv
`default_nettype none
// tb_step_controller: directed self-checking bench; expected step_pulse
// cycle windows are queued as stimulus is driven and popped as pulses appear.
module tb_step_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        step_btn;
   logic        mode_btn;
   logic [17:0] div_limit;
   logic [7:0]  run_count;
   logic        bp_enable;
   logic [15:0] bp_addr;
   logic [15:0] addr;
   logic        step_pulse;
   logic [1:0]  mode;
   logic        busy;
   logic        halted_bp;
   logic [7:0]  steps_remaining;

   step_controller #(
      .DIV_WIDTH(18), .BURST_WIDTH(8), .ADDR_WIDTH(16), .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk(clk), .reset(reset), .step_btn(step_btn), .mode_btn(mode_btn),
      .div_limit(div_limit), .run_count(run_count), .bp_enable(bp_enable),
      .bp_addr(bp_addr), .addr(addr), .step_pulse(step_pulse), .mode(mode),
      .busy(busy), .halted_bp(halted_bp), .steps_remaining(steps_remaining)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int lo;
      int hi;
   } win_t;

   win_t exp_q[$];
   win_t mon_w;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int lo, input int hi);
      win_t w;
      w.lo = lo;
      w.hi = hi;
      exp_q.push_back(w);
   endtask

   // Every pulse must match the oldest queued window.
   always @(negedge clk) begin
      if (step_pulse === 1'b1) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_pulse: observed pulse at cycle %0d expected none", cyc);
         end
         if (exp_q.size() != 0) begin
            mon_w = exp_q.pop_front();
            checks++;
            assert (cyc >= mon_w.lo && cyc <= mon_w.hi) else begin
               errors++;
               $error("FAIL pulse_time: observed cycle %0d expected %0d..%0d", cyc, mon_w.lo, mon_w.hi);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish by 200us expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic wait_mode(input logic [1:0] val, input string tag, output int at);
      int n = 0;
      while (mode !== val && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_reached"}, 32'(mode === val), 32'd1);
      at = cyc;
   endtask

   task automatic wait_busy(input string tag, output int at);
      int n = 0;
      while (busy !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_busy"}, 32'(busy), 32'd1);
      at = cyc;
   endtask

   task automatic press_mode(input logic [1:0] target, input string tag, output int at);
      mode_btn = 1'b1;
      wait_mode(target, tag, at);
      mode_btn = 1'b0;
   endtask

   // Button rises mid-cycle; 2 sync + 4 stable + 1 output register.
   task automatic step_press_expect(input string tag);
      push(cyc + 6, cyc + 8);
      step_btn = 1'b1;
      tick(10);
      step_btn = 1'b0;
      tick(10);
      check(tag, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_pulse"},  32'(step_pulse),      32'd0);
      check({tag, "_mode"},   32'(mode),            32'd0);
      check({tag, "_busy"},   32'(busy),            32'd0);
      check({tag, "_halted"}, 32'(halted_bp),       32'd0);
      check({tag, "_steps"},  32'(steps_remaining), 32'd0);
   endtask

   initial begin
      int e, r, a;
      reset     = 1'b1;
      step_btn  = 1'b0;
      mode_btn  = 1'b0;
      div_limit = 18'd3;
      run_count = 8'd5;
      bp_enable = 1'b0;
      bp_addr   = 16'h0203;
      addr      = 16'h0000;
      tick(3);
      check_all_zero("reset_held");
      reset = 1'b0;
      tick(2);
      check_all_zero("after_reset");

      // MANUAL: one pulse per press, glitch ignored
      step_press_expect("manual_one_pulse");
      step_btn = 1'b1;
      tick(2);
      step_btn = 1'b0;
      tick(12);
      check("glitch_no_pulse", 32'(exp_q.size()), 32'd0);
      check("manual_mode", 32'(mode), 32'd0);

      // AUTO: period div_limit+1, then live change to every cycle
      press_mode(2'd1, "auto_entry", e);
      for (int k = 1; k <= 4; k++) push(e + 4 * k, e + 4 * k);
      wait_until(e + 16);
      div_limit = 18'd0;
      for (int k = 17; k <= 24; k++) push(e + k, e + k);
      wait_until(e + 24);
      div_limit = 18'd1000;
      tick(4);
      check("auto_drained", 32'(exp_q.size()), 32'd0);
      check("auto_mode", 32'(mode), 32'd1);

      // BURST run A: 5 pulses, 2 cycles apart
      press_mode(2'd2, "burst_idle_entry", e);
      tick(8);
      check("burst_idle_busy", 32'(busy), 32'd0);
      run_count = 8'd5;
      div_limit = 18'd1;
      step_btn  = 1'b1;
      wait_busy("burst_a", r);
      step_btn = 1'b0;
      check("burst_a_steps0", 32'(steps_remaining), 32'd5);
      for (int k = 1; k <= 5; k++) push(r + 2 * k, r + 2 * k);
      for (int k = 1; k <= 5; k++) begin
         wait_until(r + 2 * k);
         check("burst_a_steps", 32'(steps_remaining), 32'(5 - k));
         check("burst_a_busy_on", 32'(busy), 32'd1);
      end
      wait_until(r + 11);
      check("burst_a_busy_off", 32'(busy), 32'd0);
      check("burst_a_steps_end", 32'(steps_remaining), 32'd0);
      check("burst_a_mode", 32'(mode), 32'd2);
      check("burst_a_drained", 32'(exp_q.size()), 32'd0);

      // BURST run B: a second step press mid-run is ignored
      tick(4);
      div_limit = 18'd4;
      step_btn  = 1'b1;
      wait_busy("burst_b", r);
      step_btn = 1'b0;
      for (int k = 1; k <= 5; k++) push(r + 5 * k, r + 5 * k);
      wait_until(r + 8);
      step_btn = 1'b1;
      wait_until(r + 18);
      step_btn = 1'b0;
      wait_until(r + 26);
      check("burst_b_busy_off", 32'(busy), 32'd0);
      check("burst_b_steps_end", 32'(steps_remaining), 32'd0);
      check("burst_b_drained", 32'(exp_q.size()), 32'd0);
      tick(8);

      // BURST with run_count = 0: nothing happens
      run_count = 8'd0;
      step_btn  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 10) step_btn = 1'b0;
         check("burst_zero_busy", 32'(busy), 32'd0);
      end
      check("burst_zero_mode", 32'(mode), 32'd2);
      check("burst_zero_drained", 32'(exp_q.size()), 32'd0);

      // Abort a run with 3 steps left
      run_count = 8'd5;
      div_limit = 18'd9;
      step_btn  = 1'b1;
      wait_busy("abort_run", r);
      step_btn = 1'b0;
      push(r + 10, r + 10);
      push(r + 20, r + 20);
      wait_until(r + 20);
      check("abort_steps_before", 32'(steps_remaining), 32'd3);
      mode_btn = 1'b1;
      wait_mode(2'd0, "abort", a);
      mode_btn = 1'b0;
      check("abort_steps", 32'(steps_remaining), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      tick(40);
      check("abort_drained", 32'(exp_q.size()), 32'd0);

      // Simultaneous mode+step in MANUAL, then breakpoint on 3rd AUTO slot
      div_limit = 18'd3;
      bp_enable = 1'b1;
      bp_addr   = 16'h0203;
      addr      = 16'h0000;
      tick(2);
      step_btn = 1'b1;
      mode_btn = 1'b1;
      wait_mode(2'd1, "simul", e);
      check("simul_no_pulse", 32'(step_pulse), 32'd0);
      push(e + 4, e + 4);
      push(e + 8, e + 8);
      step_btn = 1'b0;
      mode_btn = 1'b0;
      wait_until(e + 8);
      addr = 16'h0203;
      wait_until(e + 12);
      check("bp_mode", 32'(mode), 32'd0);
      check("bp_halted", 32'(halted_bp), 32'd1);
      check("bp_suppressed", 32'(step_pulse), 32'd0);
      tick(10);
      check("bp_drained", 32'(exp_q.size()), 32'd0);
      step_press_expect("bp_step_past");
      check("bp_halted_cleared", 32'(halted_bp), 32'd0);

      // Reset in the middle of a burst
      bp_enable = 1'b0;
      addr      = 16'h0000;
      div_limit = 18'd1000;
      press_mode(2'd1, "rst_auto", e);
      tick(8);
      press_mode(2'd2, "rst_bidle", e);
      tick(8);
      div_limit = 18'd1;
      run_count = 8'd5;
      step_btn  = 1'b1;
      wait_busy("rst_run", r);
      step_btn = 1'b0;
      wait_until(r + 1);
      @(posedge clk);
      #2 reset = 1'b1;
      #1 check("reset_gates_pulse", 32'(step_pulse), 32'd0);
      @(posedge clk);
      #1 check_all_zero("reset_mid_burst");
      @(negedge clk);
      reset = 1'b0;
      tick(10);
      check("reset_drained", 32'(exp_q.size()), 32'd0);
      check("reset_mode", 32'(mode), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/step_controller.md
Name: step_controller

Overview:
- Parametrised CPU clock-step generator; replaces the fixed manual/auto toggle + slow-clock + pulser chain.
- Produces single-cycle `step_pulse` clock enables for the CPU core.
- Modes: MANUAL single-step, AUTO free-run at programmable rate, BURST N-step run.
- Optional address breakpoint that halts AUTO/BURST runs.

Parameters:
- DIV_WIDTH, 18, width of the rate divider and of `div_limit`.
- BURST_WIDTH, 8, width of the burst step count.
- ADDR_WIDTH, 16, width of the CPU address compared for breakpoints.
- DEBOUNCE_CYCLES, 1000, consecutive stable cycles required before a button level is accepted (≥1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- step_btn  input  1  raw step button, active-high (already inverted), asynchronous.
- mode_btn  input  1  raw mode button, active-high, asynchronous.
- div_limit  input  DIV_WIDTH  AUTO/BURST pulse period minus one.
- run_count  input  BURST_WIDTH  number of steps per BURST run.
- bp_enable  input  1  breakpoint enable.
- bp_addr  input  ADDR_WIDTH  breakpoint address.
- addr  input  ADDR_WIDTH  current CPU address bus.
- step_pulse  output  1  one-cycle CPU clock enable.
- mode  output  2  0=MANUAL, 1=AUTO, 2=BURST (3 never driven).
- busy  output  1  high while a BURST run is in progress.
- halted_bp  output  1  sticky flag: last run stopped on a breakpoint.
- steps_remaining  output  BURST_WIDTH  steps left in the current burst.

Behaviour:

Reset (sync, highest priority):
- All outputs and counters go to 0; state = MANUAL.
- `step_pulse` is 0 in any cycle where reset is high.

Buttons:
- Each button passes through a 2-FF synchroniser, then a debouncer.
- The debounced level changes only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive cycles.
- A "press" is a 1-cycle strobe on a 0→1 transition of the debounced level. Releases generate nothing.

Mode cycling:
- A mode press moves MANUAL→AUTO→BURST_IDLE→MANUAL.
- From BURST_RUN, a mode press aborts the run: state = MANUAL, `steps_remaining` = 0.
- If mode and step presses fall in the same cycle, mode wins and the step press is discarded.

States:
- MANUAL: each step press gives `step_pulse` = 1 in the following cycle (latency 1 from the press strobe). Exactly one pulse per press; no breakpoint check. A step press clears `halted_bp`.
- AUTO: divider counts 0..div_limit and wraps. A pulse fires on the cycle the counter equals div_limit.
  - Divider is cleared on entry, so the first pulse comes div_limit+1 cycles after entry.
  - div_limit = 0 gives a pulse every cycle.
  - `div_limit` is sampled live.
  - Step presses are ignored.
- BURST_IDLE: a step press loads `steps_remaining` = run_count, clears the divider and `halted_bp`, and enters BURST_RUN.
  - run_count = 0 → no load; stay in BURST_IDLE.
- BURST_RUN: `busy` = 1. Pulses are issued at the same divider cadence as AUTO.
  - Each pulse decrements `steps_remaining`.
  - After the pulse that takes it to 0, return to BURST_IDLE with `busy` = 0 the next cycle.
  - Step presses are ignored.

Breakpoint (AUTO and BURST_RUN only):
- Checked on the cycle a pulse would fire: bp_enable = 1 and addr == bp_addr.
- On a hit:
  - the pulse is suppressed;
  - `halted_bp` is set to 1;
  - state = MANUAL;
  - `steps_remaining` is held (not decremented);
  - `busy` = 0 the next cycle.
- In MANUAL a step at the breakpoint address still pulses, so the user can step past it.

`mode` output: registered and updated in the same cycle as the state register.

Widths:
- Divider and step counter wrap/saturate never: compare-to-limit and stop at 0, respectively.

Test Plan:
- Reset / MANUAL stepping (DEBOUNCE_CYCLES=4): reset, then hold step_btn high 10 cycles → exactly one `step_pulse` ~7 cycles after the rising edge (2 sync + 4 stable + 1). A 2-cycle glitch → no pulse.
- AUTO rate: mode press once, div_limit=3 → `mode`=1 and pulses every 4 cycles, first 4 cycles after entry. Change div_limit to 0 → a pulse every cycle.
- BURST: two mode presses, run_count=5, div_limit=1, step press → exactly 5 pulses 2 cycles apart, `steps_remaining` 5→0, `busy` high throughout and low after the last pulse. A second step press mid-run → no effect.
- BURST run_count=0: step press → no pulses, `busy` stays 0.
- Breakpoint: AUTO, bp_enable=1, bp_addr=16'h0203, drive addr=16'h0203 at the 3rd pulse slot → only 2 pulses, `halted_bp`=1, `mode`=0. A following step press → 1 pulse and `halted_bp`=0.
- Abort / simultaneous / mid-run reset:
  - mode press during BURST_RUN with 3 steps left → `mode`=0, `steps_remaining`=0, no further pulses.
  - mode+step press in the same cycle in MANUAL → `mode`=1, no pulse.
  - reset asserted mid-burst → all outputs 0 the next cycle.
